// File: rtl/bf_pkg.sv
// Shared definitions for the bilateral filter normalization stage.
package bf_pkg;

    // Default datapath widths: 21-bit weight sum times 8-bit pixel.
    localparam int unsigned NUM_W_DEF = 29;
    localparam int unsigned DEN_W_DEF = 21;
    localparam int unsigned Q_W_DEF   = 8;

    // Largest representable output pixel at the default quotient width.
    localparam logic [Q_W_DEF-1:0] PIX_MAX = '1;

    // Normalizer control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPrep = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/bilateral_norm_div.sv
// Normalization stage of the bilateral filter: pix = round(num / den), clipped to the
// pixel range, computed with a sequential restoring divider (one quotient bit per cycle).
module bilateral_norm_div
    import bf_pkg::*;
#(
    parameter int unsigned NUM_W = NUM_W_DEF,
    parameter int unsigned DEN_W = DEN_W_DEF,
    parameter int unsigned Q_W   = Q_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   pix,
    output logic             sat,
    output logic             div_zero
);

    // Rounded dividend needs one extra bit; the saturation compare needs room for den << Q_W.
    localparam int unsigned REM_W = NUM_W + 1;
    localparam int unsigned CMP_W = NUM_W + Q_W + 1;
    localparam int unsigned CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    localparam logic [Q_W-1:0] PixMax = {Q_W{1'b1}};

    state_e             state_q;
    logic [NUM_W-1:0]   num_q;
    logic [DEN_W-1:0]   den_q;
    logic [REM_W-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [Q_W-1:0]     quo_q;
    logic [Q_W-1:0]     pix_q;
    logic               sat_q;
    logic               div_zero_q;
    logic               out_valid_q;

    logic [REM_W-1:0]   rem_init_d;
    logic [REM_W-1:0]   rem_step_d;
    logic [Q_W-1:0]     quo_d;
    logic [CMP_W-1:0]   sat_limit;
    logic [CMP_W-1:0]   trial;
    logic               den_zero;
    logic               sat_hit;
    logic               bit_set;

    // Datapath next values: rounding add, saturation test and one restoring-division step.
    always_comb begin
        // Adding den/2 before the floor division gives round-half-up.
        rem_init_d = REM_W'(num_q) + REM_W'(den_q >> 1);
        den_zero   = (den_q == '0);
        // Quotient would not fit in Q_W bits when rem >= den * 2^Q_W.
        sat_limit  = CMP_W'(den_q) << Q_W;
        sat_hit    = (CMP_W'(rem_init_d) >= sat_limit);

        trial      = CMP_W'(den_q) << cnt_q;
        bit_set    = (CMP_W'(rem_q) >= trial);
        rem_step_d = rem_q;
        quo_d      = quo_q;
        if (bit_set) begin
            // trial <= rem_q here, so truncating it to REM_W loses nothing.
            rem_step_d = rem_q - REM_W'(trial);
            quo_d      = quo_q | (Q_W'(1) << cnt_q);
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            num_q       <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quo_q       <= '0;
            pix_q       <= '0;
            sat_q       <= 1'b0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        num_q   <= num;
                        den_q   <= den;
                        state_q <= StPrep;
                    end
                end

                StPrep: begin
                    rem_q <= rem_init_d;
                    quo_q <= '0;
                    if (den_zero) begin
                        pix_q       <= '0;
                        sat_q       <= 1'b0;
                        div_zero_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else if (sat_hit) begin
                        pix_q       <= PixMax;
                        sat_q       <= 1'b1;
                        div_zero_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q   <= CNT_W'(Q_W - 1);
                        state_q <= StDiv;
                    end
                end

                StDiv: begin
                    rem_q <= rem_step_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        pix_q       <= quo_d;
                        sat_q       <= 1'b0;
                        div_zero_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                StDone: begin
                    // Result and flags hold until the writer takes them.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign pix       = pix_q;
    assign sat       = sat_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_bilateral_norm_div.sv
// Self-checking bench for bilateral_norm_div: directed cases with literal expectations,
// handshake/backpressure/reset scenarios, then randomized pairs against a behavioural model.
module tb_bilateral_norm_div;

    localparam int NUM_W = 29;
    localparam int DEN_W = 21;
    localparam int Q_W   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NUM_W-1:0] num = '0;
    logic [DEN_W-1:0] den = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [Q_W-1:0]   pix;
    logic             sat;
    logic             div_zero;

    always #5 clk = ~clk;

    bilateral_norm_div #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .Q_W   (Q_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pix       (pix),
        .sat       (sat),
        .div_zero  (div_zero)
    );

    typedef struct {
        int pix;
        int sat;
        int dz;
        int lat;
        int acc;
    } exp_t;

    exp_t expq[$];

    int cyc        = 0;
    int n_checks   = 0;
    int n_pass     = 0;
    int result_cnt = 0;
    int hs_cyc     = 0;
    int last_pix   = 0;
    int last_sat   = 0;
    int last_dz    = 0;
    int last_lat   = 0;
    bit cur_seen   = 1'b0;
    bit rand_or    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: floor((num + floor(den/2)) / den), clipped to 255; den==0 gives 0 + flag.
    function automatic exp_t model(input longint n, input longint d);
        exp_t   e;
        longint q;
        e.acc = 0;
        if (d == 0) begin
            e.pix = 0; e.sat = 0; e.dz = 1; e.lat = 2;
        end else begin
            q = (n + d / 2) / d;
            if (q > 255) begin
                e.pix = 255; e.sat = 1; e.dz = 0; e.lat = 2;
            end else begin
                e.pix = int'(q); e.sat = 0; e.dz = 0; e.lat = 10;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        $display("FAIL %s: actual no-event required event (cycle %0d)", name, cyc);
    endtask

    // Compare process: every cycle a result is (or should be) presented.
    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            cur_seen = 1'b0;
        end else if (out_valid) begin
            chk("in_ready_low_in_done", in_ready, 0);
            if (expq.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 0);
            end else begin
                if (!cur_seen) begin
                    chk("latency", cyc - expq[0].acc, expq[0].lat);
                    cur_seen = 1'b1;
                end
                chk("pix", pix, expq[0].pix);
                chk("sat", sat, expq[0].sat);
                chk("div_zero", div_zero, expq[0].dz);
                if (out_ready) begin
                    last_pix = pix;
                    last_sat = sat;
                    last_dz  = div_zero;
                    last_lat = cyc - expq[0].acc;
                    hs_cyc   = cyc;
                    void'(expq.pop_front());
                    cur_seen = 1'b0;
                    result_cnt++;
                end
            end
        end else if (expq.size() != 0 && (cyc - expq[0].acc) >= expq[0].lat) begin
            fail_evt("out_valid_missing");
            void'(expq.pop_front());
        end
    end

    // Random downstream backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_or) out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Present a pair until accepted; starts and ends just after a rising edge.
    task automatic send(input longint n, input longint d, output int acc);
        exp_t e;
        bit   got;
        got = 1'b0;
        acc = -1;
        in_valid = 1'b1;
        num = NUM_W'(n);
        den = DEN_W'(d);
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (in_ready && !reset) begin
                got   = 1'b1;
                acc   = cyc;
                e     = model(n, d);
                e.acc = cyc;
                expq.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) fail_evt("accept_timeout");
    endtask

    task automatic wait_results(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            #1;
            if (result_cnt >= target) done = 1'b1;
        end
        if (!done) fail_evt("result_timeout");
    endtask

    task automatic directed(input string tag, input longint n, input longint d,
                            input int ep, input int es, input int ez, input int el);
        exp_t m;
        int   a;
        int   r0;
        m = model(n, d);
        chk({tag, "_model_pix"}, m.pix, ep);
        chk({tag, "_model_lat"}, m.lat, el);
        out_ready = 1'b1;
        r0 = result_cnt;
        send(n, d, a);
        wait_results(r0 + 1);
        chk({tag, "_pix"}, last_pix, ep);
        chk({tag, "_sat"}, last_sat, es);
        chk({tag, "_dz"}, last_dz, ez);
        chk({tag, "_lat"}, last_lat, el);
    endtask

    initial begin
        int     a1;
        int     a2;
        int     r0;
        longint dd;
        longint nn;
        bit     drained;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pix", pix, 0);
        chk("rst_sat", sat, 0);
        chk("rst_div_zero", div_zero, 0);
        @(posedge clk);
        #1;

        directed("basic", 1000, 10, 100, 0, 0, 10);
        directed("round_up", 25, 10, 3, 0, 0, 10);
        directed("round_down", 24, 10, 2, 0, 0, 10);
        directed("max_exact", 255 * 121, 121, 255, 0, 0, 10);
        directed("div_zero", 5000, 0, 0, 0, 1, 2);
        directed("sat_small", 3000, 10, 255, 1, 0, 2);
        directed("sat_big", (64'd1 << 29) - 1, 1, 255, 1, 0, 2);

        // Backpressure: hold 5 cycles, then release together with a new pair.
        out_ready = 1'b0;
        r0 = result_cnt;
        send(1000, 10, a1);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_pix", pix, 100);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(24, 10, a2);
        chk("simul_accept_delay", a2 - hs_cyc, 1);
        wait_results(r0 + 2);
        chk("simul_pix", last_pix, 2);

        // Back-to-back initiation interval.
        r0 = result_cnt;
        send(1000, 10, a1);
        send(25, 10, a2);
        chk("b2b_spacing", a2 - a1, 11);
        wait_results(r0 + 2);

        // Reset during the fourth divide cycle must abort with no result.
        r0 = result_cnt;
        send(1000, 7, a1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_pix", pix, 0);
        @(posedge clk);
        #1;
        directed("after_reset", 640, 64, 10, 0, 0, 10);
        chk("abort_no_result", result_cnt, r0 + 1);

        // Randomized pairs with random gaps and backpressure.
        rand_or = 1'b1;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 7))
                0:       dd = 0;
                1, 2, 3: dd = $urandom_range(1, 300);
                4, 5:    dd = $urandom_range(1, (1 << 21) - 1);
                default: dd = $urandom_range(100, 5000);
            endcase
            case ($urandom_range(0, 3))
                0:       nn = longint'($urandom) & 64'h1FFF_FFFF;
                1, 2:    nn = dd * $urandom_range(0, 280) + $urandom_range(0, int'(dd));
                default: nn = $urandom_range(0, 5000);
            endcase
            nn = nn & 64'h1FFF_FFFF;
            send(nn, dd, a1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_or = 1'b0;
        #3;
        out_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 200 && !drained; i++) begin
            @(posedge clk);
            #1;
            if (expq.size() == 0) drained = 1'b1;
        end
        if (!drained) fail_evt("drain_timeout");
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
